// File: rtl/vm2002_pkg.sv
// Shared types and constants for the vending machine coin interface.
package vm2002_pkg;

  // Coin encoding used both for coins accepted and for change paid out.
  typedef enum logic [1:0] {
    NO_COINS = 2'b00,
    NICKEL   = 2'b01,
    DIME     = 2'b10,
    QUARTER  = 2'b11
  } coins_t;

  // Transaction result reported alongside done.
  typedef enum logic [1:0] {
    NO_STATUS    = 2'b00,
    AVAILABE     = 2'b01,
    OUT_OF_STOCK = 2'b10,
    ERROR        = 2'b11
  } status_t;

  // Bit positions of the one-hot change dispenser state vector.
  typedef enum int unsigned {
    CHG_IDLE_IDX   = 0,
    CHG_SELECT_IDX = 1,
    CHG_EMIT_IDX   = 2,
    CHG_DONE_IDX   = 3
  } change_state_index_t;

  // One-hot change dispenser states.
  typedef enum logic [3:0] {
    CHG_IDLE   = 4'b0001,
    CHG_SELECT = 4'b0010,
    CHG_EMIT   = 4'b0100,
    CHG_DONE   = 4'b1000
  } change_state_t;

  localparam logic [7:0] NICKEL_CENTS  = 8'd5;
  localparam logic [7:0] DIME_CENTS    = 8'd10;
  localparam logic [7:0] QUARTER_CENTS = 8'd25;

  // Face value in cents of a coin code; NO_COINS is worth nothing.
  function automatic logic [7:0] coin_cents(input coins_t coin);
    logic [7:0] cents;
    case (coin)
      QUARTER: cents = QUARTER_CENTS;
      DIME:    cents = DIME_CENTS;
      NICKEL:  cents = NICKEL_CENTS;
      default: cents = 8'd0;
    endcase
    return cents;
  endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin chooser: largest in-stock coin whose value fits the remainder.
module coin_select
  import vm2002_pkg::*;
#(
  parameter int AMT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [CNT_W-1:0] quarter_cnt,
  input  logic [CNT_W-1:0] dime_cnt,
  input  logic [CNT_W-1:0] nickel_cnt,
  output coins_t           coin,
  output logic [AMT_W-1:0] value
);

  localparam logic [AMT_W-1:0] QUARTER_AMT = AMT_W'(QUARTER_CENTS);
  localparam logic [AMT_W-1:0] DIME_AMT    = AMT_W'(DIME_CENTS);
  localparam logic [AMT_W-1:0] NICKEL_AMT  = AMT_W'(NICKEL_CENTS);
  localparam logic [CNT_W-1:0] EMPTY       = {CNT_W{1'b0}};

  // Priority pick from the largest denomination downward.
  always_comb begin
    coin = NO_COINS;
    if ((remaining >= QUARTER_AMT) && (quarter_cnt != EMPTY)) begin
      coin = QUARTER;
    end else if ((remaining >= DIME_AMT) && (dime_cnt != EMPTY)) begin
      coin = DIME;
    end else if ((remaining >= NICKEL_AMT) && (nickel_cnt != EMPTY)) begin
      coin = NICKEL;
    end else begin
      coin = NO_COINS;
    end
    value = AMT_W'(coin_cents(coin));
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: greedy QUARTER/DIME/NICKEL emission over a
// valid/ack handshake, with per-denomination inventory tracking.
module change_dispenser
  import vm2002_pkg::*;
#(
  parameter int AMT_W      = 8,
  parameter int CNT_W      = 4,
  parameter int INIT_COUNT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_req,
  input  logic [AMT_W-1:0] change_amount,
  output logic             req_ready,
  output logic             coin_valid,
  output coins_t           coin_out,
  input  logic             coin_ack,
  output logic             done,
  output status_t          status,
  output logic [AMT_W-1:0] shortfall,
  input  logic             restock,
  output logic [CNT_W-1:0] quarter_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic [CNT_W-1:0] nickel_cnt
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(INIT_COUNT);
  localparam logic [CNT_W-1:0] ONE_COIN   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AMT_W-1:0] NICKEL_AMT = AMT_W'(NICKEL_CENTS);
  localparam logic [AMT_W-1:0] ZERO_AMT   = {AMT_W{1'b0}};

  change_state_t    state_r, state_nxt_s;
  logic [AMT_W-1:0] remaining_r, remaining_nxt_s;
  logic [AMT_W-1:0] coin_value_r, coin_value_nxt_s;
  logic [AMT_W-1:0] shortfall_nxt_s, sel_value_s;
  logic [CNT_W-1:0] quarter_nxt_s, dime_nxt_s, nickel_nxt_s;
  coins_t           sel_coin_s, coin_out_nxt_s;
  status_t          status_nxt_s;
  logic             coin_valid_nxt_s, done_nxt_s, req_ready_nxt_s;

  coin_select #(
    .AMT_W(AMT_W),
    .CNT_W(CNT_W)
  ) u_coin_select (
    .remaining  (remaining_r),
    .quarter_cnt(quarter_cnt),
    .dime_cnt   (dime_cnt),
    .nickel_cnt (nickel_cnt),
    .coin       (sel_coin_s),
    .value      (sel_value_s)
  );

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_nxt_s      = state_r;
    remaining_nxt_s  = remaining_r;
    coin_value_nxt_s = coin_value_r;
    quarter_nxt_s    = quarter_cnt;
    dime_nxt_s       = dime_cnt;
    nickel_nxt_s     = nickel_cnt;
    coin_out_nxt_s   = NO_COINS;
    coin_valid_nxt_s = 1'b0;
    status_nxt_s     = NO_STATUS;
    shortfall_nxt_s  = ZERO_AMT;

    case (state_r)
      CHG_IDLE: begin
        if (restock) begin
          // Restock wins over a simultaneous request, which is dropped.
          quarter_nxt_s = FULL_COUNT;
          dime_nxt_s    = FULL_COUNT;
          nickel_nxt_s  = FULL_COUNT;
          state_nxt_s   = CHG_IDLE;
        end else if (change_req) begin
          if ((change_amount % NICKEL_AMT) != ZERO_AMT) begin
            // Amounts not payable in nickels are rejected without paying.
            state_nxt_s     = CHG_DONE;
            status_nxt_s    = ERROR;
            shortfall_nxt_s = change_amount;
          end else begin
            remaining_nxt_s = change_amount;
            state_nxt_s     = CHG_SELECT;
          end
        end else begin
          state_nxt_s = CHG_IDLE;
        end
      end

      CHG_SELECT: begin
        if (sel_coin_s != NO_COINS) begin
          state_nxt_s      = CHG_EMIT;
          coin_out_nxt_s   = sel_coin_s;
          coin_value_nxt_s = sel_value_s;
          coin_valid_nxt_s = 1'b1;
        end else if (remaining_r == ZERO_AMT) begin
          state_nxt_s  = CHG_DONE;
          status_nxt_s = AVAILABE;
        end else begin
          state_nxt_s     = CHG_DONE;
          status_nxt_s    = OUT_OF_STOCK;
          shortfall_nxt_s = remaining_r;
        end
      end

      CHG_EMIT: begin
        if (coin_ack) begin
          // Selection guaranteed value <= remaining and count > 0.
          remaining_nxt_s = remaining_r - coin_value_r;
          case (coin_out)
            QUARTER: quarter_nxt_s = quarter_cnt - ONE_COIN;
            DIME:    dime_nxt_s    = dime_cnt - ONE_COIN;
            NICKEL:  nickel_nxt_s  = nickel_cnt - ONE_COIN;
            default: quarter_nxt_s = quarter_cnt;
          endcase
          state_nxt_s = CHG_SELECT;
        end else begin
          // Hold the offer steady until the mechanism takes it.
          coin_out_nxt_s   = coin_out;
          coin_valid_nxt_s = 1'b1;
          state_nxt_s      = CHG_EMIT;
        end
      end

      CHG_DONE: begin
        state_nxt_s = CHG_IDLE;
      end

      default: begin
        state_nxt_s = CHG_IDLE;
      end
    endcase

    done_nxt_s      = (state_nxt_s == CHG_DONE);
    req_ready_nxt_s = (state_nxt_s == CHG_IDLE);
  end

  // State, datapath and registered outputs with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= CHG_IDLE;
      remaining_r  <= ZERO_AMT;
      coin_value_r <= ZERO_AMT;
      req_ready    <= 1'b1;
      coin_valid   <= 1'b0;
      coin_out     <= NO_COINS;
      done         <= 1'b0;
      status       <= NO_STATUS;
      shortfall    <= ZERO_AMT;
      quarter_cnt  <= FULL_COUNT;
      dime_cnt     <= FULL_COUNT;
      nickel_cnt   <= FULL_COUNT;
    end else begin
      state_r      <= state_nxt_s;
      remaining_r  <= remaining_nxt_s;
      coin_value_r <= coin_value_nxt_s;
      req_ready    <= req_ready_nxt_s;
      coin_valid   <= coin_valid_nxt_s;
      coin_out     <= coin_out_nxt_s;
      done         <= done_nxt_s;
      status       <= status_nxt_s;
      shortfall    <= shortfall_nxt_s;
      quarter_cnt  <= quarter_nxt_s;
      dime_cnt     <= dime_nxt_s;
      nickel_cnt   <= nickel_nxt_s;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected coins and
// results, a monitor pops and compares on each accepted coin and done pulse.
module tb_change_dispenser;
  import vm2002_pkg::*;

  logic       clk = 1'b0;
  logic       reset, change_req, coin_ack, restock;
  logic [7:0] change_amount;
  logic       req_ready, coin_valid, done;
  coins_t     coin_out;
  status_t    status;
  logic [7:0] shortfall;
  logic [3:0] quarter_cnt, dime_cnt, nickel_cnt;

  change_dispenser #(.AMT_W(8), .CNT_W(4), .INIT_COUNT(8)) dut (
    .clk(clk), .reset(reset), .change_req(change_req),
    .change_amount(change_amount), .req_ready(req_ready),
    .coin_valid(coin_valid), .coin_out(coin_out), .coin_ack(coin_ack),
    .done(done), .status(status), .shortfall(shortfall), .restock(restock),
    .quarter_cnt(quarter_cnt), .dime_cnt(dime_cnt), .nickel_cnt(nickel_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    coins_t     coin;
    int         cycles;
    status_t    st;
    logic [7:0] sf;
    logic [3:0] q, d, n;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   fails = 0;
  int   cyc = 0;
  int   req_cyc = 0;
  int   hold_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_coin(input coins_t c, input int cycles, input int lat);
    exp_t e;
    e.is_done = 1'b0; e.coin = c; e.cycles = cycles; e.st = NO_STATUS;
    e.sf = 8'd0; e.q = 4'd0; e.d = 4'd0; e.n = 4'd0; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input status_t st, input logic [7:0] sf,
                           input logic [3:0] q, input logic [3:0] d,
                           input logic [3:0] n, input int lat);
    exp_t e;
    e.is_done = 1'b1; e.coin = NO_COINS; e.cycles = 0; e.st = st;
    e.sf = sf; e.q = q; e.d = d; e.n = n; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Cycle counter advanced on every active edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Coin mechanism model: acks an offer unless told to stall for some cycles.
  initial begin
    coin_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (coin_valid) begin
        if (hold_left > 0) begin
          coin_ack = 1'b0;
          hold_left--;
        end else begin
          coin_ack = 1'b1;
        end
      end else begin
        coin_ack = 1'b0;
      end
    end
  end

  // Monitor: compares accepted coins and done pulses against the queue.
  initial begin
    bit     in_offer;
    bit     stable_bad;
    coins_t first_coin;
    int     vcyc;
    int     first_cyc;
    exp_t   e;
    in_offer = 1'b0; stable_bad = 1'b0; vcyc = 0; first_cyc = 0;
    first_coin = NO_COINS;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (coin_valid) begin
          if (!in_offer) begin
            in_offer = 1'b1; first_coin = coin_out; vcyc = 1; first_cyc = cyc;
            stable_bad = 1'b0;
          end else begin
            vcyc++;
            if (coin_out !== first_coin) stable_bad = 1'b1;
          end
          if (coin_ack) begin
            if (exp_q.size() == 0) begin
              check("unexpected_coin", 32'(coin_out), 32'(NO_COINS));
            end else begin
              e = exp_q.pop_front();
              check("coin_kind", 32'(e.is_done), 32'd0);
              check("coin_value", 32'(coin_out), 32'(e.coin));
              check("coin_stable", 32'(stable_bad), 32'd0);
              check("coin_offer_cycles", 32'(vcyc), 32'(e.cycles));
              if (e.lat >= 0) check("first_coin_latency", 32'(first_cyc - req_cyc), 32'(e.lat));
            end
            in_offer = 1'b0;
          end
        end else begin
          in_offer = 1'b0;
          check("idle_coin_out", 32'(coin_out), 32'(NO_COINS));
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("done_kind", 32'(e.is_done), 32'd1);
            check("done_status", 32'(status), 32'(e.st));
            check("done_shortfall", 32'(shortfall), 32'(e.sf));
            check("done_quarter_cnt", 32'(quarter_cnt), 32'(e.q));
            check("done_dime_cnt", 32'(dime_cnt), 32'(e.d));
            check("done_nickel_cnt", 32'(nickel_cnt), 32'(e.n));
            if (e.lat >= 0) check("done_latency", 32'(cyc - req_cyc), 32'(e.lat));
          end
        end else begin
          check("idle_status", 32'(status), 32'(NO_STATUS));
          check("idle_shortfall", 32'(shortfall), 32'd0);
        end
      end
    end
  end

  // Issue one request and wait (bounded) for its done pulse.
  task automatic run_txn(input logic [7:0] amt);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) check("req_ready_timeout", 32'd1, 32'd0);
    change_amount = amt;
    change_req = 1'b1;
    req_cyc = cyc;
    @(posedge clk); #1;
    change_req = 1'b0;
    guard = 0;
    while (guard < 500) begin
      @(negedge clk);
      if (done) break;
      guard++;
    end
    if (guard >= 500) check("done_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_restock();
    restock = 1'b1;
    @(posedge clk); #1;
    restock = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; change_req = 1'b0; restock = 1'b0; change_amount = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_coin_valid", 32'(coin_valid), 32'd0);
    check("rst_coin_out", 32'(coin_out), 32'(NO_COINS));
    check("rst_done", 32'(done), 32'd0);
    check("rst_status", 32'(status), 32'(NO_STATUS));
    check("rst_shortfall", 32'(shortfall), 32'd0);
    check("rst_quarter_cnt", 32'(quarter_cnt), 32'd8);
    check("rst_dime_cnt", 32'(dime_cnt), 32'd8);
    check("rst_nickel_cnt", 32'(nickel_cnt), 32'd8);
    reset = 1'b0;
    @(posedge clk); #1;

    // 40 cents from full stock: Q, D, N.
    push_coin(QUARTER, 1, 2); push_coin(DIME, 1, -1); push_coin(NICKEL, 1, -1);
    push_done(AVAILABE, 8'd0, 4'd7, 4'd7, 4'd7, 8);
    run_txn(8'd40);

    // Zero amount: done two cycles after the request.
    push_done(AVAILABE, 8'd0, 4'd7, 4'd7, 4'd7, 2);
    run_txn(8'd0);

    // Restock, then drain quarters down to one with 175 cents.
    do_restock();
    for (int i = 0; i < 7; i++) push_coin(QUARTER, 1, -1);
    push_done(AVAILABE, 8'd0, 4'd1, 4'd8, 4'd8, -1);
    run_txn(8'd175);

    // Single quarter left: 55 -> Q, D, D, D.
    push_coin(QUARTER, 1, -1);
    for (int i = 0; i < 3; i++) push_coin(DIME, 1, -1);
    push_done(AVAILABE, 8'd0, 4'd0, 4'd5, 4'd8, -1);
    run_txn(8'd55);

    // Drain dimes (50) then nickels down to two (30).
    for (int i = 0; i < 5; i++) push_coin(DIME, 1, -1);
    push_done(AVAILABE, 8'd0, 4'd0, 4'd0, 4'd8, -1);
    run_txn(8'd50);
    for (int i = 0; i < 6; i++) push_coin(NICKEL, 1, -1);
    push_done(AVAILABE, 8'd0, 4'd0, 4'd0, 4'd2, -1);
    run_txn(8'd30);

    // Stock Q=0/D=0/N=2, 25 cents -> N, N, then out of stock with 15 owed.
    push_coin(NICKEL, 1, -1); push_coin(NICKEL, 1, -1);
    push_done(OUT_OF_STOCK, 8'd15, 4'd0, 4'd0, 4'd0, -1);
    run_txn(8'd25);

    // Not a multiple of 5: immediate error, inventory untouched.
    push_done(ERROR, 8'd42, 4'd0, 4'd0, 4'd0, 1);
    run_txn(8'd42);

    // Restock and request together: restock wins, no transaction starts.
    restock = 1'b1; change_req = 1'b1; change_amount = 8'd40;
    @(posedge clk); #1;
    restock = 1'b0; change_req = 1'b0;
    check("restock_req_ready", 32'(req_ready), 32'd1);
    check("restock_quarter_cnt", 32'(quarter_cnt), 32'd8);
    check("restock_dime_cnt", 32'(dime_cnt), 32'd8);
    check("restock_nickel_cnt", 32'(nickel_cnt), 32'd8);
    repeat (4) @(posedge clk);
    #1;
    check("restock_no_coin", 32'(coin_valid), 32'd0);

    // 40 cents with the first coin stalled three cycles.
    hold_left = 3;
    push_coin(QUARTER, 4, 2); push_coin(DIME, 1, -1); push_coin(NICKEL, 1, -1);
    push_done(AVAILABE, 8'd0, 4'd7, 4'd7, 4'd7, -1);
    run_txn(8'd40);

    // Reset while a coin is on offer.
    hold_left = 1000;
    change_amount = 8'd40; change_req = 1'b1;
    @(posedge clk); #1;
    change_req = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_coin_valid", 32'(coin_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_emit_reset_valid", 32'(coin_valid), 32'd0);
    check("mid_emit_reset_coin", 32'(coin_out), 32'(NO_COINS));
    @(posedge clk); #1;
    reset = 1'b0;
    hold_left = 0;
    @(posedge clk); #1;
    check("post_reset_req_ready", 32'(req_ready), 32'd1);
    check("post_reset_quarter_cnt", 32'(quarter_cnt), 32'd8);
    check("post_reset_dime_cnt", 32'(dime_cnt), 32'd8);
    check("post_reset_nickel_cnt", 32'(nickel_cnt), 32'd8);
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_coin_valid", 32'(coin_valid), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Coin-output end of the vending machine's coin interface: the FSM accepts coins in through coins_t, and this block pays change back out through the same encoding. It takes a change amount from the main FSM at END_TRANSACTION and emits a greedy sequence of QUARTER/DIME/NICKEL coins, one per valid/ack handshake, to the coin-return mechanism. It tracks its own coin inventory and reports any shortfall when stock runs out.

Parameters:
AMT_W, 8, width of the change amount in cents (maximum 255)
CNT_W, 4, width of each per-denomination inventory counter
INIT_COUNT, 8, inventory value per denomination after reset and after restock

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
change_req  input  1  request; sampled only while req_ready=1
change_amount  input  AMT_W  change owed in cents; captured with change_req
req_ready  output  1  high only in IDLE
coin_valid  output  1  coin_out holds a coin being offered
coin_out  output  2  coins_t value; NO_COINS whenever coin_valid=0
coin_ack  input  1  coin mechanism accepted coin_out this cycle
done  output  1  one-cycle pulse at the end of a transaction
status  output  2  status_t result, valid while done=1, NO_STATUS otherwise
shortfall  output  AMT_W  unpaid cents, valid while done=1, 0 otherwise
restock  input  1  reload all inventories to INIT_COUNT; honoured only in IDLE
quarter_cnt, dime_cnt, nickel_cnt  output  CNT_W each  current inventory

Behaviour:
- Reset is asynchronous, active-high, and clock is clk; these are fixed. On reset: state=IDLE, req_ready=1, coin_valid=0, coin_out=NO_COINS, done=0, status=NO_STATUS, shortfall=0, all counters=INIT_COUNT, remaining=0.
- States: IDLE, SELECT, EMIT, DONE.
- IDLE:
  - When change_req=1, capture change_amount into remaining and go to SELECT.
  - If restock=1 in the same cycle as change_req=1, restock has priority. Counters reload and the request is ignored; req_ready stays high.
  - restock is ignored in every state except IDLE.
- Validity check: if change_amount mod 5 != 0, go directly to DONE with status=ERROR, shortfall=change_amount, and no coins emitted.
- SELECT (1 cycle): pick the largest coin with value <= remaining and count > 0. Values are 25/10/5.
  - Coin found: go to EMIT.
  - remaining=0: go to DONE with status=AVAILABE.
  - remaining>0 and no coin fits: go to DONE with status=OUT_OF_STOCK and shortfall=remaining.
- EMIT:
  - coin_valid=1; coin_out stays stable until coin_ack.
  - On coin_valid & coin_ack: subtract the coin value from remaining, decrement that coin's counter, deassert coin_valid, and return to SELECT.
  - No decrement ever occurs without ack.
- DONE (1 cycle): done=1 with status/shortfall driven, then return to IDLE.
- Latency:
  - Request cycle N gives SELECT at N+1 and the first coin_valid at N+2.
  - Each coin costs 1 SELECT cycle plus at least 1 EMIT cycle.
  - Zero amount gives done at N+2.
- Arithmetic:
  - remaining is AMT_W bits and never underflows, because the selection guarantees value <= remaining.
  - Counters are CNT_W bits and never decrement below 0, because selection requires count > 0.
- Reset mid-EMIT: coin_valid drops immediately (async). The offered coin is not counted and inventory reloads to INIT_COUNT.
- change_req outside IDLE is ignored; the requester must wait for req_ready.

Decomposition:
- Add to vm2002_pkg:
  - change_state_t, a one-hot enum with an index enum in the style of state_index.
  - Coin value constants NICKEL_CENTS=5, DIME_CENTS=10, QUARTER_CENTS=25.
  - Reuse coins_t and status_t as-is.
- One combinational sub-module, coin_select: inputs remaining and the three counts; outputs the chosen coins_t and its value (NO_COINS/0 if none fits).

Test Plan:
- Counts 8/8/8, change_amount=40 -> coins QUARTER, DIME, NICKEL with immediate acks; done with AVAILABE, shortfall=0; counts 7/7/7.
- change_amount=0 -> no coin_valid; done pulses 2 cycles after the request with AVAILABE.
- Counts Q=1/D=8/N=8, change_amount=55 -> QUARTER, DIME, DIME, DIME; AVAILABE; counts 0/5/8.
- Counts Q=0/D=0/N=2, change_amount=25 -> NICKEL, NICKEL; done with OUT_OF_STOCK, shortfall=15; counts 0/0/0.
- change_amount=42 -> no coins; done with ERROR, shortfall=42; counts unchanged.
- coin_ack held low 3 cycles during the first coin of 40 -> coin_out=QUARTER stable for 4 cycles, then continues normally.
- reset asserted mid-EMIT -> coin_valid=0 the same cycle; req_ready=1 and counts=8/8/8 afterward.
